wb_master_bridge: RTL and testbench

Converts the core-side single-request memory port (address, byte select, enable, write enable, write data → read data, busy) into classic Wishbone B4 master cycles. Sits directly downstream of the core memory controller's WB port and upstream of the SoC Wishbone interconnect. It registers each request, holds CYC/STB until the slave acknowledges or errors, and returns read data with a busy flag. The memory controller samples data and busy one cycle after issuing the request.

---
 rtl/wb_master_pkg.sv | 16 +
 rtl/wb_timeout_counter.sv | 28 ++
 rtl/wb_master_bridge.sv | 111 +++++++++++
 tb/tb_wb_master_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for the core-to-Wishbone master bridge.
package wb_master_pkg;

   localparam int WB_ADDR_WIDTH = 28;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8;

   // Read result substituted whenever a cycle ends in error or timeout.
   localparam logic [WB_DATA_WIDTH-1:0] WB_ERROR_DATA = 32'hFFFFFFFF;

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } wbState_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts bus cycles without a slave response and flags the cycle in which
// the allowed budget is used up.
module wb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_WIDTH  = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMEOUT_WIDTH-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // The count holds the number of silent cycles already spent, so this
   // cycle is the last one allowed when it equals TIMEOUT_CYCLES-1.
   assign expired = enable && (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_master_bridge.sv
// Core single-request memory port to classic Wishbone B4 master bridge.
// Optional bus-cycle timeout is compiled in with WB_MASTER_TIMEOUT_EN.
module wb_master_bridge
   import wb_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int TIMEOUT_WIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WB_ADDR_WIDTH-1:0] wbAddress,
   input  logic [WB_SEL_WIDTH-1:0]  wbByteSelect,
   input  logic                     wbEnable,
   input  logic                     wbWriteEnable,
   input  logic [WB_DATA_WIDTH-1:0] wbDataWrite,
   output logic [WB_DATA_WIDTH-1:0] wbDataRead,
   output logic                     wbBusy,
   output logic                     wb_cyc_o,
   output logic                     wb_stb_o,
   output logic                     wb_we_o,
   output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
   output logic [WB_SEL_WIDTH-1:0]  wb_sel_o,
   output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
   input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
   input  logic                     wb_ack_i,
   input  logic                     wb_err_i,
   output logic                     busError
);

   wbState_t state;
   logic     timeoutExpired;

   if (TIMEOUT_CYCLES >= (1 << TIMEOUT_WIDTH)) begin : gTimeoutWidthCheck
      $error("TIMEOUT_WIDTH too narrow to count TIMEOUT_CYCLES");
   end

   // Busy comes straight from the state register so the controller sees it
   // without any combinational dependence on its own request strobe.
   assign wbBusy = (state == BUS);

`ifdef WB_MASTER_TIMEOUT_EN
   wb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
   ) uTimeoutCounter (
      .clk    (clk),
      .rst    (rst),
      .clear  (state == IDLE),
      .enable ((state == BUS) && !wb_ack_i && !wb_err_i),
      .expired(timeoutExpired)
   );
`else
   assign timeoutExpired = 1'b0;
`endif

   // NOTE: every register here is assigned with <= so that all of them see
   // the pre-edge values; busError defaults low each cycle to form a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wbDataRead <= WB_ERROR_DATA;
         busError   <= 1'b0;
         wb_cyc_o   <= 1'b0;
         wb_stb_o   <= 1'b0;
         wb_we_o    <= 1'b0;
         wb_adr_o   <= '0;
         wb_sel_o   <= '0;
         wb_dat_o   <= '0;
      end else begin
         busError <= 1'b0;
         unique case (state)
            IDLE: begin
               if (wbEnable) begin
                  wb_adr_o <= wbAddress;
                  wb_we_o  <= wbWriteEnable;
                  wb_sel_o <= wbWriteEnable ? wbByteSelect : '0;
                  wb_dat_o <= wbWriteEnable ? wbDataWrite : '0;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  state    <= BUS;
               end
            end
            BUS: begin
               // Error outranks ack; ack outranks a timeout in the same cycle.
               if (wb_err_i) begin
                  wbDataRead <= WB_ERROR_DATA;
                  busError   <= 1'b1;
                  wb_cyc_o   <= 1'b0;
                  wb_stb_o   <= 1'b0;
                  state      <= IDLE;
               end else if (wb_ack_i) begin
                  if (!wb_we_o) begin
                     wbDataRead <= wb_dat_i;
                  end
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  state    <= IDLE;
               end else if (timeoutExpired) begin
                  wbDataRead <= WB_ERROR_DATA;
                  busError   <= 1'b1;
                  wb_cyc_o   <= 1'b0;
                  wb_stb_o   <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized self-checking bench for wb_master_bridge against a
// transaction-level reference model (read-data register and bus contents).
module tb_wb_master_bridge;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [27:0] wbAddress;
   logic [3:0]  wbByteSelect;
   logic        wbEnable;
   logic        wbWriteEnable;
   logic [31:0] wbDataWrite;
   logic [31:0] wbDataRead;
   logic        wbBusy;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [27:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        wb_err_i;
   logic        busError;

   int          compareCount  = 0;
   int          mismatchCount = 0;
   logic [31:0] modelRead;

   wb_master_bridge #(
      .TIMEOUT_CYCLES(TB_TIMEOUT),
      .TIMEOUT_WIDTH (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wbAddress    (wbAddress),
      .wbByteSelect (wbByteSelect),
      .wbEnable     (wbEnable),
      .wbWriteEnable(wbWriteEnable),
      .wbDataWrite  (wbDataWrite),
      .wbDataRead   (wbDataRead),
      .wbBusy       (wbBusy),
      .wb_cyc_o     (wb_cyc_o),
      .wb_stb_o     (wb_stb_o),
      .wb_we_o      (wb_we_o),
      .wb_adr_o     (wb_adr_o),
      .wb_sel_o     (wb_sel_o),
      .wb_dat_o     (wb_dat_o),
      .wb_dat_i     (wb_dat_i),
      .wb_ack_i     (wb_ack_i),
      .wb_err_i     (wb_err_i),
      .busError     (busError)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkResetState(input string tag);
      check({tag, "_cyc"}, wb_cyc_o, 1'b0);
      check({tag, "_stb"}, wb_stb_o, 1'b0);
      check({tag, "_we"}, wb_we_o, 1'b0);
      check({tag, "_adr"}, wb_adr_o, 28'h0);
      check({tag, "_sel"}, wb_sel_o, 4'h0);
      check({tag, "_dat"}, wb_dat_o, 32'h0);
      check({tag, "_busy"}, wbBusy, 1'b0);
      check({tag, "_buserr"}, busError, 1'b0);
      check({tag, "_rdata"}, wbDataRead, 32'hFFFFFFFF);
   endtask

   // Idle cycles with stray ack/err noise that must not disturb anything.
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         wbEnable = 1'b0;
         wb_ack_i = 1'($urandom);
         wb_err_i = 1'($urandom);
         wb_dat_i = $urandom;
         @(posedge clk); #1;
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         check("idle_cyc", wb_cyc_o, 1'b0);
         check("idle_busy", wbBusy, 1'b0);
         check("idle_buserr", busError, 1'b0);
         check("idle_rdata", wbDataRead, modelRead);
      end
   endtask

   // Issue one request from an IDLE cycle and let the slave answer after
   // `waits` wait states; ends at the first IDLE cycle after completion.
   task automatic doTransaction(input logic [27:0] addr, input logic [3:0] sel, input logic we,
                                input logic [31:0] data, input int waits, input logic useErr,
                                input logic ackToo, input logic [31:0] slaveData);
      logic [3:0]  expSel;
      logic [31:0] expDat;
      expSel = we ? sel : 4'h0;
      expDat = we ? data : 32'h0;
      wbAddress     = addr;
      wbByteSelect  = sel;
      wbWriteEnable = we;
      wbDataWrite   = data;
      wbEnable      = 1'b1;
      @(posedge clk); #1;
      check("start_buserr", busError, 1'b0);
      for (int k = 0; k <= waits; k++) begin
         // Request inputs change freely while the bus cycle is in flight.
         wbEnable      = 1'($urandom);
         wbAddress     = 28'($urandom);
         wbByteSelect  = 4'($urandom);
         wbWriteEnable = 1'($urandom);
         wbDataWrite   = $urandom;
         check("bus_cyc", wb_cyc_o, 1'b1);
         check("bus_stb", wb_stb_o, 1'b1);
         check("bus_busy", wbBusy, 1'b1);
         check("bus_adr", wb_adr_o, addr);
         check("bus_sel", wb_sel_o, expSel);
         check("bus_dat", wb_dat_o, expDat);
         check("bus_we", wb_we_o, we);
         wb_dat_i = (k == waits) ? slaveData : $urandom;
         wb_ack_i = (k == waits) && (!useErr || ackToo);
         wb_err_i = (k == waits) && useErr;
         @(posedge clk); #1;
      end
      wbEnable = 1'b0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = $urandom;
      if (useErr) modelRead = 32'hFFFFFFFF;
      else if (!we) modelRead = slaveData;
      check("done_cyc", wb_cyc_o, 1'b0);
      check("done_stb", wb_stb_o, 1'b0);
      check("done_busy", wbBusy, 1'b0);
      check("done_rdata", wbDataRead, modelRead);
      check("done_buserr", busError, useErr);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      int busyCycles;
      rst = 1'b1;
      wbAddress = '0; wbByteSelect = '0; wbEnable = 1'b0; wbWriteEnable = 1'b0;
      wbDataWrite = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
      modelRead = 32'hFFFFFFFF;
      repeat (3) @(posedge clk);
      #1;
      checkResetState("reset");
      rst = 1'b0;
      idleCycles(2);

      // Directed cases from the intended use.
      doTransaction(28'h0000010, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'hDEADBEEF);
      doTransaction(28'h0000020, 4'h3, 1'b1, 32'h12345678, 3, 1'b0, 1'b0, 32'hCAFEF00D);
      doTransaction(28'h0000030, 4'hC, 1'b0, 32'h0, 1, 1'b1, 1'b1, 32'h01234567);
      idleCycles(1);
      doTransaction(28'h0000040, 4'hF, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'hA5A5A5A5);
      doTransaction(28'h0000044, 4'h1, 1'b1, 32'h55AA55AA, 2, 1'b0, 1'b0, 32'h0);
      doTransaction(28'h0000048, 4'hF, 1'b0, 32'h0, 1, 1'b0, 1'b0, 32'h5A5A5A5A);

      // Randomized traffic, back-to-back or separated by noisy idle cycles.
      for (int i = 0; i < 60; i++) begin
         doTransaction(28'($urandom), 4'($urandom), 1'($urandom), $urandom,
                       int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                       1'($urandom), $urandom);
         if ($urandom_range(0, 2) == 0) idleCycles(int'($urandom_range(1, 2)));
      end

      // Reset while a read is in flight; a late ack must be ignored.
      wbAddress = 28'h0000050; wbByteSelect = 4'hF; wbWriteEnable = 1'b0; wbEnable = 1'b1;
      @(posedge clk); #1;
      wbEnable = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_cyc", wb_cyc_o, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkResetState("midbus_reset");
      modelRead = 32'hFFFFFFFF;
      wb_dat_i = 32'h13572468;
      wb_ack_i = 1'b1;
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      check("late_ack_cyc", wb_cyc_o, 1'b0);
      check("late_ack_rdata", wbDataRead, modelRead);
      check("late_ack_buserr", busError, 1'b0);

      // Silent slave: aborted by the timeout when compiled in, else held.
      wbAddress = 28'h0000060; wbByteSelect = 4'hF; wbWriteEnable = 1'b0; wbEnable = 1'b1;
      @(posedge clk); #1;
      wbEnable = 1'b0;
      busyCycles = 0;
      while (wbBusy && busyCycles < 1000) begin
         busyCycles++;
         @(posedge clk); #1;
      end
`ifdef WB_MASTER_TIMEOUT_EN
      modelRead = 32'hFFFFFFFF;
      check("timeout_cycles", busyCycles, TB_TIMEOUT);
      check("timeout_cyc", wb_cyc_o, 1'b0);
      check("timeout_buserr", busError, 1'b1);
      check("timeout_rdata", wbDataRead, modelRead);
`else
      check("hold_cycles", busyCycles, 1000);
      check("hold_busy", wbBusy, 1'b1);
      check("hold_cyc", wb_cyc_o, 1'b1);
      wb_dat_i = 32'h2468ACE0;
      wb_ack_i = 1'b1;
      @(posedge clk); #1;
      wb_ack_i = 1'b0;
      modelRead = 32'h2468ACE0;
      check("hold_done_rdata", wbDataRead, modelRead);
      check("hold_done_busy", wbBusy, 1'b0);
`endif
      idleCycles(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
